// File: rtl/ahb_mstage_pkg.sv
// Shared types for the AHB-Lite master-side stage: FSM states, bus encodings
// and the slot index type (wide enough for up to 16 slots).
package ahb_mstage_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PEND,
    DATA,
    ERR1,
    ERR2
  } state_t;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_t;

  typedef logic [3:0] slot_idx_t;

endpackage

// File: rtl/ahb_mstage_default_slave.sv
// Built-in default slave for unmapped slots: answers with the two-cycle
// AHB ERROR pattern (HREADY low + ERROR, then HREADY high + ERROR).
module ahb_mstage_default_slave
  import ahb_mstage_pkg::*;
(
  input  state_t state,
  output logic   active,
  output logic   hready,
  output logic   hresp
);

  // ERR1 stalls the master with ERROR, ERR2 completes the errored transfer
  always_comb begin
    active = 1'b0;
    hready = 1'b1;
    hresp  = HRESP_OKAY;
    case (state)
      ERR1: begin
        active = 1'b1;
        hready = 1'b0;
        hresp  = HRESP_ERROR;
      end
      ERR2: begin
        active = 1'b1;
        hready = 1'b1;
        hresp  = HRESP_ERROR;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ahb_master_stage.sv
// Master-side stage of the AHB-Lite matrix. Decodes the master address phase
// into a one-hot slot request, holds it while the slot arbiter withholds the
// grant, then steers the selected slot's data-phase response back.
// Optional error logger enabled with `define AHB_MSTAGE_ERRLOG_EN.
module ahb_master_stage
  import ahb_mstage_pkg::*;
#(
  parameter int                   NUM_SLOTS = 8,
  parameter int                   SLOT_BITS = 3,
  parameter logic [NUM_SLOTS-1:0] SLOT_EN   = '1
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic [31:0]               HADDR,
  input  logic [1:0]                HTRANS,
  input  logic                      HWRITE,
  input  logic [2:0]                HSIZE,
  input  logic                      HMASTLOCK,
  output logic                      HREADY,
  output logic                      HRESP,
  output logic [31:0]               HRDATA,
  output logic [NUM_SLOTS-1:0]      SREQ,
  output logic                      SLOCK,
  input  logic [NUM_SLOTS-1:0]      SGRANT,
  output logic [31:0]               SADDR,
  output logic [1:0]                STRANS,
  output logic                      SWRITE,
  output logic [2:0]                SSIZE,
  input  logic [NUM_SLOTS-1:0]      SREADY,
  input  logic [NUM_SLOTS-1:0]      SRESP,
  input  logic [32*NUM_SLOTS-1:0]   SRDATA
`ifdef AHB_MSTAGE_ERRLOG_EN
  ,
  output logic                      ERR_VALID,
  output logic [31:0]               ERR_ADDR,
  input  logic                      ERR_CLR
`endif
);

  state_t                 state_reg, state_next;
  logic [31:0]            hold_addr_reg;
  logic [1:0]             hold_trans_reg;
  logic                   hold_write_reg;
  logic [2:0]             hold_size_reg;
  logic                   hold_lock_reg;
  logic [NUM_SLOTS-1:0]   hold_oh_reg;
  logic [NUM_SLOTS-1:0]   dslot_oh_reg;
  logic                   dlock_reg;

  slot_idx_t              live_slot;
  logic [NUM_SLOTS-1:0]   live_oh, live_req;
  logic                   live_mapped, live_go, pend_go, valid_phase;
  logic                   data_ready, data_resp, hready_int;
  logic                   err_active, err_hready, err_hresp;
  logic [31:0]            rdata_terms [NUM_SLOTS];
  logic [31:0]            rdata_mux;

  assign live_slot = slot_idx_t'(HADDR[31 -: SLOT_BITS]);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      assign live_oh[gi]     = (live_slot == slot_idx_t'(gi));
      assign rdata_terms[gi] = dslot_oh_reg[gi] ? SRDATA[32*gi +: 32] : 32'h0;
    end
  endgenerate

  // OR together the masked per-slot read data (only the data-phase slot is non-zero)
  always_comb begin
    rdata_mux = 32'h0;
    for (int i = 0; i < NUM_SLOTS; i++) rdata_mux = rdata_mux | rdata_terms[i];
  end

  ahb_mstage_default_slave u_default_slave (
    .state  (state_reg),
    .active (err_active),
    .hready (err_hready),
    .hresp  (err_hresp)
  );

  assign data_ready = |(dslot_oh_reg & SREADY);
  assign data_resp  = |(dslot_oh_reg & SRESP);

  // Ready to master: default slave, held phase, or the data-phase slot
  always_comb begin
    hready_int = 1'b1;
    if (err_active)              hready_int = err_hready;
    else if (state_reg == PEND)  hready_int = 1'b0;
    else if (state_reg == DATA)  hready_int = data_ready;
  end
  assign HREADY = hready_int;

  // Reset blocks new requests so nothing is forwarded while the stage is being cleared
  assign valid_phase = HTRANS[1] & hready_int & ~HRESET;
  assign live_mapped = |(live_oh & SLOT_EN);
  assign live_req    = (valid_phase && live_mapped) ? live_oh : '0;
  assign live_go     = |(live_req & SGRANT & SREADY);
  assign pend_go     = |(hold_oh_reg & SGRANT & SREADY);

  // Slot-side source mux and master-side response steering
  always_comb begin
    SREQ   = live_req;
    SADDR  = HADDR;
    STRANS = (|live_req) ? HTRANS : HTRANS_IDLE;
    SWRITE = HWRITE;
    SSIZE  = HSIZE;
    SLOCK  = 1'b0;
    HRESP  = err_active ? err_hresp : HRESP_OKAY;
    HRDATA = 32'h0;
    if (state_reg == PEND) begin
      SREQ   = hold_oh_reg;
      SADDR  = hold_addr_reg;
      STRANS = hold_trans_reg;
      SWRITE = hold_write_reg;
      SSIZE  = hold_size_reg;
      SLOCK  = hold_lock_reg;
    end else if (state_reg == DATA) begin
      SLOCK  = dlock_reg;
      HRESP  = data_resp;
      HRDATA = rdata_mux;
    end
  end

  // Next state: a new valid phase is decoded the same way from every ready state
  always_comb begin
    state_next = state_reg;
    if (valid_phase) begin
      if (!live_mapped)  state_next = ERR1;
      else if (live_go)  state_next = DATA;
      else               state_next = PEND;
    end else begin
      case (state_reg)
        PEND:    if (pend_go) state_next = DATA;
        DATA:    if (data_ready) state_next = IDLE;
        ERR1:    state_next = ERR2;
        ERR2:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // State, hold registers for a withheld phase, and data-phase slot/lock
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_reg      <= IDLE;
      hold_addr_reg  <= 32'h0;
      hold_trans_reg <= HTRANS_IDLE;
      hold_write_reg <= 1'b0;
      hold_size_reg  <= 3'h0;
      hold_lock_reg  <= 1'b0;
      hold_oh_reg    <= '0;
      dslot_oh_reg   <= '0;
      dlock_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (valid_phase && live_mapped && !live_go) begin
        hold_addr_reg  <= HADDR;
        hold_trans_reg <= HTRANS;
        hold_write_reg <= HWRITE;
        hold_size_reg  <= HSIZE;
        hold_lock_reg  <= HMASTLOCK;
        hold_oh_reg    <= live_oh;
      end
      if (live_go) begin
        dslot_oh_reg <= live_oh;
        dlock_reg    <= HMASTLOCK;
      end else if (state_reg == PEND && pend_go) begin
        dslot_oh_reg <= hold_oh_reg;
        dlock_reg    <= hold_lock_reg;
      end
    end
  end

`ifdef AHB_MSTAGE_ERRLOG_EN
  logic [31:0] daddr_reg;
  logic        err_valid_reg;
  logic [31:0] err_addr_reg;
  logic        err_event;

  // One event per errored transfer, on its completing cycle
  assign err_event = (state_reg == ERR2) ||
                     (state_reg == DATA && data_ready && data_resp);

  // Track the data-phase address and keep the first error until cleared
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      daddr_reg     <= 32'h0;
      err_valid_reg <= 1'b0;
      err_addr_reg  <= 32'h0;
    end else begin
      if (valid_phase)                        daddr_reg <= HADDR;
      else if (state_reg == PEND && pend_go)  daddr_reg <= hold_addr_reg;
      if (err_event && (!err_valid_reg || ERR_CLR)) begin
        err_valid_reg <= 1'b1;
        err_addr_reg  <= daddr_reg;
      end else if (ERR_CLR) begin
        err_valid_reg <= 1'b0;
      end
    end
  end

  assign ERR_VALID = err_valid_reg;
  assign ERR_ADDR  = err_addr_reg;
`endif

endmodule

// File: tb/tb_ahb_master_stage.sv
// Self-checking bench for ahb_master_stage (slot 7 unmapped). Expected values
// come from per-transfer parameters: grant delay, slave wait, data, response.
module tb_ahb_master_stage;

  localparam logic [7:0] SLOT_EN_TB = 8'h7F;

  logic         HCLK = 1'b0;
  logic         HRESET;
  logic [31:0]  HADDR;
  logic [1:0]   HTRANS;
  logic         HWRITE;
  logic [2:0]   HSIZE;
  logic         HMASTLOCK;
  logic         HREADY, HRESP;
  logic [31:0]  HRDATA;
  logic [7:0]   SREQ;
  logic         SLOCK;
  logic [7:0]   SGRANT;
  logic [31:0]  SADDR;
  logic [1:0]   STRANS;
  logic         SWRITE;
  logic [2:0]   SSIZE;
  logic [7:0]   SREADY, SRESP;
  logic [255:0] SRDATA;
`ifdef AHB_MSTAGE_ERRLOG_EN
  logic         ERR_VALID;
  logic [31:0]  ERR_ADDR;
  logic         ERR_CLR = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  ahb_master_stage #(.NUM_SLOTS(8), .SLOT_BITS(3), .SLOT_EN(SLOT_EN_TB)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HMASTLOCK(HMASTLOCK), .HREADY(HREADY), .HRESP(HRESP),
    .HRDATA(HRDATA), .SREQ(SREQ), .SLOCK(SLOCK), .SGRANT(SGRANT), .SADDR(SADDR),
    .STRANS(STRANS), .SWRITE(SWRITE), .SSIZE(SSIZE), .SREADY(SREADY),
    .SRESP(SRESP), .SRDATA(SRDATA)
`ifdef AHB_MSTAGE_ERRLOG_EN
    , .ERR_VALID(ERR_VALID), .ERR_ADDR(ERR_ADDR), .ERR_CLR(ERR_CLR)
`endif
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic cyc();
    @(posedge HCLK);
    #1;
  endtask

  // Master idle with junk address; slave-side signals random
  task automatic bg();
    HTRANS    = 2'b00;
    HADDR     = $urandom;
    HWRITE    = 1'($urandom);
    HSIZE     = 3'($urandom_range(0, 2));
    HMASTLOCK = 1'b0;
    SGRANT    = 8'($urandom);
    SREADY    = 8'($urandom);
    SRESP     = 8'($urandom);
    for (int i = 0; i < 8; i++) SRDATA[32*i +: 32] = $urandom;
  endtask

  // A cycle in which the arbiter does not accept: no grant, or grant with slot busy
  task automatic withhold(input int slot);
    if ($urandom_range(0, 1) == 0) begin
      SGRANT[slot] = 1'b0;
      SREADY[slot] = 1'($urandom);
    end else begin
      SGRANT[slot] = 1'b1;
      SREADY[slot] = 1'b0;
    end
  endtask

  task automatic idle_chk();
    cyc(); bg(); #4;
    chk("idle_hready", {31'h0, HREADY}, 32'h1);
    chk("idle_hresp",  {31'h0, HRESP},  32'h0);
    chk("idle_sreq",   {24'h0, SREQ},   32'h0);
    chk("idle_slock",  {31'h0, SLOCK},  32'h0);
    chk("idle_strans", {30'h0, STRANS}, 32'h0);
    chk("idle_hrdata", HRDATA,          32'h0);
  endtask

  // One complete transfer: gw withheld cycles, sw slave wait states
  task automatic xfer(input logic [31:0] addr, input logic wr, input logic lk,
                      input int gw, input int sw, input logic [31:0] rdata, input logic err);
    int         slot;
    logic       mapped;
    logic [7:0] oh;
    logic [2:0] sz;
    slot   = int'(addr[31:29]);
    mapped = SLOT_EN_TB[slot];
    oh     = 8'h00;
    oh[slot] = 1'b1;
    sz     = 3'($urandom_range(0, 2));
    // address phase
    cyc(); bg();
    HADDR = addr; HTRANS = 2'b10; HWRITE = wr; HSIZE = sz; HMASTLOCK = lk;
    if (mapped) begin
      if (gw == 0) begin SGRANT[slot] = 1'b1; SREADY[slot] = 1'b1; end
      else withhold(slot);
    end
    #4;
    chk("aph_hready", {31'h0, HREADY}, 32'h1);
    chk("aph_sreq", {24'h0, SREQ}, mapped ? {24'h0, oh} : 32'h0);
    if (mapped) begin
      chk("aph_saddr", SADDR, addr);
      chk("aph_strans", {30'h0, STRANS}, 32'h2);
      chk("aph_swrite", {31'h0, SWRITE}, {31'h0, wr});
    end else begin
      cyc(); bg(); #4;
      chk("err1_hready", {31'h0, HREADY}, 32'h0);
      chk("err1_hresp",  {31'h0, HRESP},  32'h1);
      chk("err1_sreq",   {24'h0, SREQ},   32'h0);
      cyc(); bg(); #4;
      chk("err2_hready", {31'h0, HREADY}, 32'h1);
      chk("err2_hresp",  {31'h0, HRESP},  32'h1);
      chk("err2_sreq",   {24'h0, SREQ},   32'h0);
      return;
    end
    // withheld cycles: phase held towards the slot, master stalled
    for (int k = 1; k <= gw; k++) begin
      cyc(); bg();
      if (k == gw) begin SGRANT[slot] = 1'b1; SREADY[slot] = 1'b1; end
      else withhold(slot);
      #4;
      chk("pend_hready", {31'h0, HREADY}, 32'h0);
      chk("pend_sreq",   {24'h0, SREQ},   {24'h0, oh});
      chk("pend_saddr",  SADDR,           addr);
      chk("pend_swrite", {31'h0, SWRITE}, {31'h0, wr});
      chk("pend_ssize",  {29'h0, SSIZE},  {29'h0, sz});
      chk("pend_slock",  {31'h0, SLOCK},  {31'h0, lk});
    end
    // data phase
    for (int k = 0; k <= sw; k++) begin
      cyc(); bg();
      SREADY[slot] = (k == sw);
      SRESP[slot]  = err;
      if (k == sw) SRDATA[32*slot +: 32] = rdata;
      #4;
      chk("dph_hready", {31'h0, HREADY}, (k == sw) ? 32'h1 : 32'h0);
      chk("dph_hresp",  {31'h0, HRESP},  {31'h0, err});
      chk("dph_slock",  {31'h0, SLOCK},  {31'h0, lk});
      if (k == sw) chk("dph_hrdata", HRDATA, rdata);
    end
  endtask

  initial begin
    HRESET = 1'b1;
    HTRANS = 2'b00; HADDR = 32'h0; HWRITE = 1'b0; HSIZE = 3'h0; HMASTLOCK = 1'b0;
    SGRANT = 8'h0; SREADY = 8'hFF; SRESP = 8'h0; SRDATA = '0;
    repeat (3) cyc();
    HRESET = 1'b0;

    // reset then idle for 5 cycles
    repeat (5) idle_chk();
`ifdef AHB_MSTAGE_ERRLOG_EN
    chk("rst_err_valid", {31'h0, ERR_VALID}, 32'h0);
    chk("rst_err_addr",  ERR_ADDR,           32'h0);
`endif

    // granted read to slot 1, zero wait
    xfer(32'h2000_0010, 1'b0, 1'b0, 0, 0, 32'hCAFE_0001, 1'b0);
    // write to slot 3 withheld three cycles
    xfer(32'h6000_0000, 1'b1, 1'b0, 3, 0, 32'h0, 1'b0);
    idle_chk();
    // unmapped slot 7 -> default slave
    xfer(32'hE000_0000, 1'b0, 1'b0, 0, 0, 32'h0, 1'b0);
    idle_chk();

    // locked back-to-back pair to slot 2
    cyc(); bg();
    HADDR = 32'h4000_0000; HTRANS = 2'b10; HMASTLOCK = 1'b1; HWRITE = 1'b0;
    SGRANT[2] = 1'b1; SREADY[2] = 1'b1;
    #4;
    chk("lk1_sreq", {24'h0, SREQ}, 32'h04);
    cyc(); bg();
    HADDR = 32'h4000_0004; HTRANS = 2'b11; HMASTLOCK = 1'b1;
    SGRANT[2] = 1'b1; SREADY[2] = 1'b1; SRESP[2] = 1'b0;
    #4;
    chk("lk1_slock",  {31'h0, SLOCK},  32'h1);
    chk("lk2_sreq",   {24'h0, SREQ},   32'h04);
    chk("lk2_strans", {30'h0, STRANS}, 32'h3);
    cyc(); bg();
    SREADY[2] = 1'b1; SRESP[2] = 1'b0; SRDATA[64 +: 32] = 32'h1234_5678;
    #4;
    chk("lk2_slock",  {31'h0, SLOCK}, 32'h1);
    chk("lk2_hrdata", HRDATA,         32'h1234_5678);
    idle_chk();

    // reset while a phase is pending
    cyc(); bg();
    HADDR = 32'h4000_0040; HTRANS = 2'b10; SGRANT[2] = 1'b0;
    #4;
    chk("rp_sreq", {24'h0, SREQ}, 32'h04);
    cyc(); bg();
    SGRANT[2] = 1'b0; HRESET = 1'b1;
    #4;
    chk("rp_pend_hready", {31'h0, HREADY}, 32'h0);
    cyc(); bg();
    HRESET = 1'b0;
    #4;
    chk("rp_after_hready", {31'h0, HREADY}, 32'h1);
    chk("rp_after_sreq",   {24'h0, SREQ},   32'h0);
    chk("rp_after_hresp",  {31'h0, HRESP},  32'h0);

`ifdef AHB_MSTAGE_ERRLOG_EN
    xfer(32'hE000_0100, 1'b0, 1'b0, 0, 0, 32'h0, 1'b0);
    xfer(32'hE000_0200, 1'b1, 1'b0, 0, 0, 32'h0, 1'b0);
    idle_chk();
    chk("log_valid", {31'h0, ERR_VALID}, 32'h1);
    chk("log_addr",  ERR_ADDR,           32'hE000_0100);
    cyc(); bg(); ERR_CLR = 1'b1;
    cyc(); bg(); ERR_CLR = 1'b0;
    #4;
    chk("log_cleared", {31'h0, ERR_VALID}, 32'h0);
`endif

    // randomized transfers
    for (int t = 0; t < 40; t++) begin
      logic [2:0]  s3;
      logic [31:0] a;
      s3 = 3'($urandom);
      a  = {s3, 29'($urandom)};
      xfer(a, 1'($urandom), 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 2),
           $urandom, ($urandom_range(0, 4) == 0));
      if ($urandom_range(0, 1) == 0) idle_chk();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
